hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised scoreboard that replaces the fixed lw-only hazard check and the
//  two-source forwarding unit of the 5-stage core. Tracks every in-flight register
//  write with a per-destination latency: ALU=1, load=2, multi-cycle up to DEPTH.
//  Sits beside the IF/ID register. Stalls the ID instruction until all its sources
//  are forwardable. Emits forward-select codes for ID and registered codes for EX.
// PARAMETERS
//  NREG   32  architectural registers (r0 hard-wired zero, never tracked)
//  RAW     5  register address width, = clog2(NREG)
//  DEPTH   3  stages after ID up to and including RF write (EX,MEM,WB)
//  AGEW    2  age/forward-code width, = clog2(DEPTH+1)
//  LATW    2  latency field width
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  id_valid   in   1        ID holds a real instruction
//  id_flush   in   1        ID instruction squashed (taken branch/jump)
//  id_ra      in   RAW      source A register
//  id_rb      in   RAW      source B register
//  id_use_a   in   1        instruction reads ra
//  id_use_b   in   1        instruction reads rb
//  id_wr_en   in   1        instruction writes id_rd
//  id_rd      in   RAW      destination register (after RegDst mux)
//  id_lat     in   LATW     cycles from EX entry until result is forwardable
//  stall      out  1        hold PC and IF/ID; insert bubble into ID/EX
//  id_fwd_a   out  AGEW     forward code for source A, combinational
//  id_fwd_b   out  AGEW     forward code for source B, combinational
//  ex_fwd_a   out  AGEW     id_fwd_a registered into EX
//  ex_fwd_b   out  AGEW     id_fwd_b registered into EX
//  busy_mask  out  NREG     bit r set while r has a tracked pending write
//  stall_cnt  out  32       saturating count of stall cycles
// BEHAVIOUR
//  Per register r: cnt[r] (0..DEPTH) and age[r] (0..DEPTH). busy = age!=0.
//  issue = id_valid & ~id_flush & ~stall.
//  Issue with id_wr_en & id_rd!=0 loads cnt[id_rd]=lat_eff and age[id_rd]=1.
//   lat_eff = id_lat clamped to [1,DEPTH]: 0->1, >DEPTH->DEPTH.
//  All other busy entries update each cycle:
//   - cnt decrements, saturating at 0.
//   - age increments; an entry at age==DEPTH goes to age=0, cnt=0 (written to RF).
//  Same-cycle issue and retire/update on one register: the issue wins.
//  WAW: a new issue to a busy rd overwrites the entry; the youngest writer is tracked.
//  Hazard on source X (a/b): use_X & X!=0 & busy[X] & cnt[X]>1.
//  stall = id_valid & ~id_flush & (hazard_a | hazard_b); forced 0 while rst.
//  id_fwd_X = 0 when unused, X==0, or not busy; otherwise age[X]. Code meaning at
//   the consumer's EX cycle: 1=EX/MEM reg, 2=MEM/WB reg, 3=WB busW, 0=regfile.
//  ex_fwd_a/b load id_fwd_a/b on issue; load 0 on stall, flush or ~id_valid (bubble).
//  stall_cnt increments on each cycle stall=1 and holds at 32'hFFFFFFFF.
//  Stalled cycles allocate nothing. Existing entries keep aging during stalls.
//  Reset: all cnt/age=0, busy_mask=0, ex_fwd_a/b=0, stall_cnt=0, stall=0.
//   Reset mid-operation discards every pending entry.
//  Latency: stall and id_fwd are same-cycle. ex_fwd follows one cycle later.
//   lat=L stalls a dependent instruction issued the next cycle for L-1 cycles.
// TESTING
//  1 ALU chain: issue r3 lat1; next cycle read r3 -> stall=0, id_fwd_a=1; ex_fwd_a=1
//    the following cycle. A reader 2 cycles later gets fwd=2; 3 cycles later gets 3.
//  2 Load-use: issue r5 lat2; next cycle read r5 as B -> stall=1 for exactly one
//    cycle, stall_cnt=1. Then issue with id_fwd_b=2. Cycle after age 3, r5 not busy.
//  3 r0: write r0 lat3, then read r0 -> busy_mask=0, stall=0, fwd=0.
//  4 WAW: r4 lat3 at t, r4 lat1 at t+1, reader of r4 at t+2 -> stall=0, fwd=1.
//  5 Flush: id_valid=1, id_flush=1, wr r6 -> no allocation. Later read r6 -> fwd=0,
//    stall=0, and ex_fwd=0 in the flushed slot.
//  6 Reset mid-op: r7 lat3 pending and a reader stalled; pulse rst -> next cycle
//    busy_mask=0, stall=0, stall_cnt=0, ex_fwd_a/b=0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request/response bundle between decode and the hazard scoreboard
//
// Purpose: carries the decoded ID instruction's register usage to the scoreboard
//          and returns stall / forward-select information.
// Signals (driven by master = decode side):
//   id_valid, id_flush          ID slot holds an instruction / instruction squashed
//   id_ra, id_rb                source register addresses
//   id_use_a, id_use_b          instruction reads ra / rb
//   id_wr_en, id_rd, id_lat     destination write enable, address, result latency
// Signals (driven by slave = scoreboard):
//   stall                       hold PC and IF/ID, bubble into ID/EX
//   id_fwd_a, id_fwd_b          combinational forward codes for ID
//   ex_fwd_a, ex_fwd_b          forward codes registered into EX
//   busy_mask                   per-register pending-write flags
//   stall_cnt                   saturating stall-cycle counter
interface hazard_scoreboard_if #(
    parameter int NREG = 32,
    parameter int RAW  = 5,
    parameter int AGEW = 2,
    parameter int LATW = 2
);
    logic            id_valid;
    logic            id_flush;
    logic [RAW-1:0]  id_ra;
    logic [RAW-1:0]  id_rb;
    logic            id_use_a;
    logic            id_use_b;
    logic            id_wr_en;
    logic [RAW-1:0]  id_rd;
    logic [LATW-1:0] id_lat;
    logic            stall;
    logic [AGEW-1:0] id_fwd_a;
    logic [AGEW-1:0] id_fwd_b;
    logic [AGEW-1:0] ex_fwd_a;
    logic [AGEW-1:0] ex_fwd_b;
    logic [NREG-1:0] busy_mask;
    logic [31:0]     stall_cnt;

    modport master (
        output id_valid, id_flush, id_ra, id_rb, id_use_a, id_use_b,
               id_wr_en, id_rd, id_lat,
        input  stall, id_fwd_a, id_fwd_b, ex_fwd_a, ex_fwd_b, busy_mask, stall_cnt
    );

    modport slave (
        input  id_valid, id_flush, id_ra, id_rb, id_use_a, id_use_b,
               id_wr_en, id_rd, id_lat,
        output stall, id_fwd_a, id_fwd_b, ex_fwd_a, ex_fwd_b, busy_mask, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register latency/age scoreboard producing stall and forward codes
//
// Purpose: tracks the youngest in-flight write to every register (except r0) with a
//          remaining-latency counter and a pipeline age. Stalls the ID instruction
//          while any source is not yet forwardable and reports where each source
//          will be found when the consumer reaches EX.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   sb    hazard_scoreboard_if slave modport (ID request in, stall/forwarding out)
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int RAW   = 5,
    parameter int DEPTH = 3,
    parameter int AGEW  = 2,
    parameter int LATW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   sb
);
    localparam logic [AGEW-1:0] ONE     = AGEW'(1);
    localparam logic [AGEW-1:0] AGE_MAX = AGEW'(DEPTH);
    localparam logic [LATW:0]   DEPTH_L = (LATW+1)'(DEPTH);

    logic [AGEW-1:0] cnt [NREG];
    logic [AGEW-1:0] age [NREG];
    logic [NREG-1:0] busy;
    logic [AGEW-1:0] lat_eff;
    logic [AGEW-1:0] fwd_a;
    logic [AGEW-1:0] fwd_b;
    logic [AGEW-1:0] ex_a_q;
    logic [AGEW-1:0] ex_b_q;
    logic [31:0]     stall_cnt_q;
    logic            hazard_a;
    logic            hazard_b;
    logic            stall_w;
    logic            issue;

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (age[r] != '0);
        end
    end

    // A source is only a hazard while its producer still needs more than one
    // cycle; cnt==1 means the value is on a forwarding path by our EX cycle.
    assign hazard_a = sb.id_use_a && (sb.id_ra != '0) && busy[sb.id_ra] && (cnt[sb.id_ra] > ONE);
    assign hazard_b = sb.id_use_b && (sb.id_rb != '0) && busy[sb.id_rb] && (cnt[sb.id_rb] > ONE);
    assign stall_w  = !rst && sb.id_valid && !sb.id_flush && (hazard_a || hazard_b);
    assign issue    = sb.id_valid && !sb.id_flush && !stall_w;

    assign fwd_a = (sb.id_use_a && (sb.id_ra != '0) && busy[sb.id_ra]) ? age[sb.id_ra] : '0;
    assign fwd_b = (sb.id_use_b && (sb.id_rb != '0) && busy[sb.id_rb]) ? age[sb.id_rb] : '0;

    always_comb begin
        lat_eff = AGEW'(sb.id_lat);
        if (sb.id_lat == '0) begin
            lat_eff = ONE;
        end else if ({1'b0, sb.id_lat} > DEPTH_L) begin
            lat_eff = AGE_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
                age[r] <= '0;
            end
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (age[r] != '0) begin
                    if (age[r] == AGE_MAX) begin
                        age[r] <= '0;
                        cnt[r] <= '0;
                    end else begin
                        age[r] <= age[r] + ONE;
                        cnt[r] <= (cnt[r] != '0) ? cnt[r] - ONE : '0;
                    end
                end
            end
            // Placed after the aging loop so a new writer overrides both the
            // retirement and any older (WAW) entry for the same register.
            if (issue && sb.id_wr_en && (sb.id_rd != '0)) begin
                cnt[sb.id_rd] <= lat_eff;
                age[sb.id_rd] <= ONE;
            end
            ex_a_q <= issue ? fwd_a : '0;
            ex_b_q <= issue ? fwd_b : '0;
            if (stall_w && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign sb.stall     = stall_w;
    assign sb.id_fwd_a  = fwd_a;
    assign sb.id_fwd_b  = fwd_b;
    assign sb.ex_fwd_a  = ex_a_q;
    assign sb.ex_fwd_b  = ex_b_q;
    assign sb.busy_mask = busy;
    assign sb.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(32), .RAW(5), .AGEW(2), .LATW(2)) bus ();

    hazard_scoreboard #(.NREG(32), .RAW(5), .DEPTH(3), .AGEW(2), .LATW(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    // Reference model: each register remembers the cycle its youngest writer
    // issued and that writer's effective latency; everything else is derived
    // from elapsed time.
    int      now = 0;
    int      wt [32];
    int      wl [32];
    int      m_exa, m_exb;
    longint  m_scnt;

    typedef struct {
        bit v, fl;
        int ra, rb;
        bit ua, ub, wr;
        int rd, lat;
        int e_stall, e_fa, e_fb, e_exa, e_exb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit v, bit fl, int ra, int rb, bit ua, bit ub, bit wr,
                                int rd, int lat, int es, int fa, int fb, int exa, int exb);
        vec_t t;
        t.v = v; t.fl = fl; t.ra = ra; t.rb = rb; t.ua = ua; t.ub = ub; t.wr = wr;
        t.rd = rd; t.lat = lat; t.e_stall = es; t.e_fa = fa; t.e_fb = fb;
        t.e_exa = exa; t.e_exb = exb;
        return t;
    endfunction

    function automatic int m_age(int r);
        int e;
        if (r == 0) return 0;
        e = now - wt[r];
        return (e >= 1 && e <= DEPTH) ? e : 0;
    endfunction

    function automatic bit m_haz(int r, bit u);
        return u && (m_age(r) != 0) && ((now - wt[r]) < wl[r]);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            wt[i] = -1000;
            wl[i] = 0;
        end
        m_exa = 0; m_exb = 0; m_scnt = 0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, now, act, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare against the model,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input bit r, input bit v, input bit fl, input int ra, input int rb,
                        input bit ua, input bit ub, input bit wr, input int rd, input int lat);
        bit          e_stall, iss;
        int          fa, fb;
        logic [31:0] e_busy;
        @(negedge clk);
        rst = r;
        bus.id_valid = v; bus.id_flush = fl;
        bus.id_ra = 5'(ra); bus.id_rb = 5'(rb);
        bus.id_use_a = ua; bus.id_use_b = ub;
        bus.id_wr_en = wr; bus.id_rd = 5'(rd); bus.id_lat = 2'(lat);
        #1;
        e_stall = !r && v && !fl && (m_haz(ra, ua) || m_haz(rb, ub));
        fa = ua ? m_age(ra) : 0;
        fb = ub ? m_age(rb) : 0;
        e_busy = '0;
        for (int i = 1; i < 32; i++) e_busy[i] = (m_age(i) != 0);
        chk("stall", 64'(bus.stall), 64'(e_stall));
        chk("id_fwd_a", 64'(bus.id_fwd_a), 64'(fa));
        chk("id_fwd_b", 64'(bus.id_fwd_b), 64'(fb));
        chk("ex_fwd_a", 64'(bus.ex_fwd_a), 64'(m_exa));
        chk("ex_fwd_b", 64'(bus.ex_fwd_b), 64'(m_exb));
        chk("busy_mask", 64'(bus.busy_mask), 64'(e_busy));
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_scnt));
        if (r) begin
            m_reset();
        end else begin
            iss = v && !fl && !e_stall;
            m_exa = iss ? fa : 0;
            m_exb = iss ? fb : 0;
            if (e_stall && m_scnt < 64'hFFFF_FFFF) m_scnt++;
            if (iss && wr && rd != 0) begin
                wt[rd] = now;
                wl[rd] = (lat == 0) ? 1 : (lat > DEPTH) ? DEPTH : lat;
            end
        end
        now++;
    endtask

    initial begin
        m_reset();
        bus.id_valid = 0; bus.id_flush = 0; bus.id_ra = 0; bus.id_rb = 0;
        bus.id_use_a = 0; bus.id_use_b = 0; bus.id_wr_en = 0; bus.id_rd = 0; bus.id_lat = 0;
        rst = 1;
        repeat (2) @(posedge clk);

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset busy_mask", 64'(bus.busy_mask), 64'd0);
        chk("reset stall_cnt", 64'(bus.stall_cnt), 64'd0);

        //            v fl ra rb ua ub wr rd lat  stall fa fb exa exb
        tbl.push_back(mk(1,0, 0,0, 0,0, 1, 3,1,   0, 0,0, 0,0));  // ALU r3
        tbl.push_back(mk(1,0, 3,0, 1,0, 0, 0,0,   0, 1,0, 0,0));
        tbl.push_back(mk(1,0, 3,0, 1,0, 0, 0,0,   0, 2,0, 1,0));
        tbl.push_back(mk(1,0, 3,0, 1,0, 0, 0,0,   0, 3,0, 2,0));
        tbl.push_back(mk(1,0, 3,0, 1,0, 0, 0,0,   0, 0,0, 3,0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 1, 5,2,   0, 0,0, 0,0));  // load r5
        tbl.push_back(mk(1,0, 0,5, 0,1, 0, 0,0,   1, 0,1, 0,0));
        tbl.push_back(mk(1,0, 0,5, 0,1, 0, 0,0,   0, 0,2, 0,0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0, 0,0,   0, 0,0, 0,2));
        tbl.push_back(mk(1,0, 0,5, 0,1, 0, 0,0,   0, 0,0, 0,0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 1, 0,3,   0, 0,0, 0,0));  // r0 write
        tbl.push_back(mk(1,0, 0,0, 1,1, 0, 0,0,   0, 0,0, 0,0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 1, 4,3,   0, 0,0, 0,0));  // WAW r4
        tbl.push_back(mk(1,0, 0,0, 0,0, 1, 4,1,   0, 0,0, 0,0));
        tbl.push_back(mk(1,0, 4,0, 1,0, 0, 0,0,   0, 1,0, 0,0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0, 0,0,   0, 0,0, 1,0));
        tbl.push_back(mk(1,1, 4,0, 1,0, 1, 6,3,   0, 3,0, 0,0));  // flushed wr r6
        tbl.push_back(mk(1,0, 6,0, 1,0, 0, 0,0,   0, 0,0, 0,0));
        tbl.push_back(mk(1,0, 0,0, 0,0, 1, 8,0,   0, 0,0, 0,0));  // lat 0 -> 1
        tbl.push_back(mk(1,0, 8,0, 1,0, 0, 0,0,   0, 1,0, 0,0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0, 0,0,   0, 0,0, 1,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(0, tbl[i].v, tbl[i].fl, tbl[i].ra, tbl[i].rb, tbl[i].ua, tbl[i].ub,
                 tbl[i].wr, tbl[i].rd, tbl[i].lat);
            chk($sformatf("tbl%0d stall", i), 64'(bus.stall), 64'(tbl[i].e_stall));
            chk($sformatf("tbl%0d id_fwd_a", i), 64'(bus.id_fwd_a), 64'(tbl[i].e_fa));
            chk($sformatf("tbl%0d id_fwd_b", i), 64'(bus.id_fwd_b), 64'(tbl[i].e_fb));
            chk($sformatf("tbl%0d ex_fwd_a", i), 64'(bus.ex_fwd_a), 64'(tbl[i].e_exa));
            chk($sformatf("tbl%0d ex_fwd_b", i), 64'(bus.ex_fwd_b), 64'(tbl[i].e_exb));
        end
        chk("load-use stall_cnt", 64'(bus.stall_cnt), 64'd1);

        // Reset in the middle of a stalled dependency
        step(0, 1, 0, 0, 0, 0, 0, 1, 7, 3);
        step(0, 1, 0, 7, 0, 1, 0, 0, 0, 0);
        chk("r7 reader stalls", 64'(bus.stall), 64'd1);
        step(1, 1, 0, 7, 0, 1, 0, 0, 0, 0);
        chk("stall forced low in rst", 64'(bus.stall), 64'd0);
        step(0, 1, 0, 7, 0, 1, 0, 0, 0, 0);
        chk("post-rst busy_mask", 64'(bus.busy_mask), 64'd0);
        chk("post-rst stall", 64'(bus.stall), 64'd0);
        chk("post-rst stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("post-rst ex_fwd_a", 64'(bus.ex_fwd_a), 64'd0);
        chk("post-rst ex_fwd_b", 64'(bus.ex_fwd_b), 64'd0);

        // Randomised traffic on a small register window to provoke overlaps
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
